seq_alu: RTL

- Parametrised, multi-cycle successor to the group's 8-bit combinational ALU.
- Keeps the FORWARD/ADD/AND/OR encodings and the ZERO flag.
- Adds SUB, sequential shift-add MUL and one-bit-per-cycle shifts, plus a CARRY flag.
- Adds a START/BUSY/DONE handshake so the CPU control unit can stall on long operations. Sits between the register file read ports and the writeback mux.

---
 rtl/seq_alu_if.sv | 25 ++
 rtl/seq_alu.sv | 136 +++++++++++++
 2 files changed

// File: rtl/seq_alu_if.sv
// Operand/result bus between the CPU control path and seq_alu.
// The master side issues START with operands; the slave side returns result, flags and handshake.
interface seq_alu_if #(
  parameter int WIDTH = 8
);
  logic             START;
  logic [2:0]       SELECT;
  logic [WIDTH-1:0] DATA1;
  logic [WIDTH-1:0] DATA2;
  logic [WIDTH-1:0] RESULT;
  logic             ZERO;
  logic             CARRY;
  logic             BUSY;
  logic             DONE;

  modport master (
    output START, SELECT, DATA1, DATA2,
    input  RESULT, ZERO, CARRY, BUSY, DONE
  );

  modport slave (
    input  START, SELECT, DATA1, DATA2,
    output RESULT, ZERO, CARRY, BUSY, DONE
  );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle FWD/ADD/AND/OR/SUB, shift-add MUL and bit-serial SLL/SRA,
// with START/BUSY/DONE handshake and registered RESULT/ZERO/CARRY.
module seq_alu #(
  parameter int WIDTH = 8
) (
  input  logic     CLK,
  input  logic     RESET,
  seq_alu_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [WIDTH-1:0] WMAX     = WIDTH'(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;
  typedef enum logic [2:0] {
    OP_FWD = 3'b000, OP_ADD = 3'b001, OP_AND = 3'b010, OP_OR  = 3'b011,
    OP_SUB = 3'b100, OP_MUL = 3'b101, OP_SLL = 3'b110, OP_SRA = 3'b111
  } op_t;

  state_t           state, state_d;
  op_t              op, op_d;
  logic [WIDTH-1:0] a, a_d, b, b_d, acc, acc_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [WIDTH-1:0] result, result_d;
  logic             zero, zero_d, carry, carry_d;
  logic             fin, fin_c;
  logic [WIDTH-1:0] fin_res;
  logic [WIDTH:0]   mul_sum;

  always_comb begin
    state_d  = state;
    op_d     = op;
    a_d      = a;
    b_d      = b;
    acc_d    = acc;
    cnt_d    = cnt;
    result_d = result;
    zero_d   = zero;
    carry_d  = carry;
    fin      = 1'b0;
    fin_c    = 1'b0;
    fin_res  = result;
    mul_sum  = '0;
    unique case (state)
      S_IDLE: begin
        if (bus.START) begin
          op_d  = op_t'(bus.SELECT);
          a_d   = bus.DATA1;
          b_d   = bus.DATA2;
          acc_d = '0;
          case (op_t'(bus.SELECT))
            OP_FWD: begin fin = 1'b1; fin_res = bus.DATA2; end
            OP_ADD: begin fin = 1'b1; {fin_c, fin_res} = {1'b0, bus.DATA1} + {1'b0, bus.DATA2}; end
            OP_AND: begin fin = 1'b1; fin_res = bus.DATA1 & bus.DATA2; end
            OP_OR:  begin fin = 1'b1; fin_res = bus.DATA1 | bus.DATA2; end
            // Extended subtraction: the top bit is the unsigned borrow
            OP_SUB: begin fin = 1'b1; {fin_c, fin_res} = {1'b0, bus.DATA1} - {1'b0, bus.DATA2}; end
            OP_MUL: begin cnt_d = CNT_FULL; state_d = S_EXEC; end
            default: begin
              if (bus.DATA2 == '0) begin
                fin     = 1'b1;
                fin_res = bus.DATA1;
              end else begin
                cnt_d   = (bus.DATA2 >= WMAX) ? CNT_FULL : CNT_W'(bus.DATA2);
                state_d = S_EXEC;
              end
            end
          endcase
        end
      end
      S_EXEC: begin
        cnt_d = cnt - CNT_ONE;
        case (op)
          OP_MUL: begin
            // {acc, b} is the running product; b's low bit is the current multiplier bit
            mul_sum = {1'b0, acc} + (b[0] ? {1'b0, a} : '0);
            acc_d   = mul_sum[WIDTH:1];
            b_d     = {mul_sum[0], b[WIDTH-1:1]};
            fin_res = b_d;
            fin_c   = |acc_d;
          end
          OP_SLL: begin
            a_d     = {a[WIDTH-2:0], 1'b0};
            fin_res = a_d;
            fin_c   = a[WIDTH-1];
          end
          default: begin
            a_d     = {a[WIDTH-1], a[WIDTH-1:1]};
            fin_res = a_d;
            fin_c   = a[0];
          end
        endcase
        fin = (cnt == CNT_ONE);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (fin) begin
      result_d = fin_res;
      zero_d   = (fin_res == '0);
      carry_d  = fin_c;
      state_d  = S_DONE;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state  <= S_IDLE;
      op     <= OP_FWD;
      a      <= '0;
      b      <= '0;
      acc    <= '0;
      cnt    <= '0;
      result <= '0;
      zero   <= 1'b1;
      carry  <= 1'b0;
    end else begin
      state  <= state_d;
      op     <= op_d;
      a      <= a_d;
      b      <= b_d;
      acc    <= acc_d;
      cnt    <= cnt_d;
      result <= result_d;
      zero   <= zero_d;
      carry  <= carry_d;
    end
  end

  assign bus.RESULT = result;
  assign bus.ZERO   = zero;
  assign bus.CARRY  = carry;
  assign bus.BUSY   = (state != S_IDLE);
  assign bus.DONE   = (state == S_DONE);
endmodule
